// File: rtl/wb_src_arbiter_if.sv
// Bus bundle between the write-back source arbiter, its six requesters and the
// downstream consumer. The master modport is the arbiter's view.
interface wb_src_arbiter_if;
  logic [5:0] req;
  logic [5:0] lock;
  logic       bus_ready;
  logic [5:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;
  logic       xfer;
  logic       timeout_err;

  modport master (
    input  req, lock, bus_ready,
    output gnt, sel, bus_valid, xfer, timeout_err
  );

  modport slave (
    output req, lock, bus_ready,
    input  gnt, sel, bus_valid, xfer, timeout_err
  );
endinterface

// File: rtl/wb_src_arbiter.sv
// Round-robin arbiter/sequencer for the six-source 16-bit write-back mux.
// Grants one requester at a time, drives the mux selector (IDLE_SEL when
// nothing is granted) and handshakes each beat with the consumer.
// Optional feature macro: WB_WATCHDOG_EN adds a stall watchdog that forces
// a release after TIMEOUT granted cycles without bus_ready.
module wb_src_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int MAX_BURST = 4,
  parameter int IDLE_SEL  = 7,
  parameter int TIMEOUT   = 15
) (
  input logic              CLK,
  input logic              RESET_N,
  wb_src_arbiter_if.master bus
);

  localparam int             BW         = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [2:0]     SEL_IDLE   = 3'(IDLE_SEL);
  localparam logic [2:0]     LAST_IDX   = 3'(NUM_REQ - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (NUM_REQ != 6 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_src_arbiter: NUM_REQ must be 6, MAX_BURST and TIMEOUT >= 1");
  end

  logic [0:0]    state_q, state_d;
  logic [5:0]    gnt_q, gnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [BW-1:0] beat_q, beat_d;

`ifdef WB_WATCHDOG_EN
  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          tout_q, tout_d;
`endif

  logic [2:0] g;
  logic [2:0] next_g;
  logic [2:0] arb_base;
  logic [2:0] win;
  logic       found;
  logic [3:0] pos;
  logic       do_arb;

  assign g        = sel_q;
  assign next_g   = (sel_q == LAST_IDX) ? 3'd0 : sel_q + 3'd1;
  // On release the old owner's successor heads the scan, so the old owner
  // automatically becomes lowest priority for the same-cycle re-arbitration.
  assign arb_base = (state_q == GRANT) ? next_g : ptr_q;

  // Round-robin scan: first set req bit from arb_base upward, wrapping 5->0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, arb_base} + 4'(k);
      if (pos >= 4'(NUM_REQ)) pos = pos - 4'(NUM_REQ);
      if (!found && bus.req[pos[2:0]]) begin
        found = 1'b1;
        win   = pos[2:0];
      end
    end
  end

  // Next-state: hold, count beats, or release and re-arbitrate in one cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    do_arb  = 1'b0;
`ifdef WB_WATCHDOG_EN
    wait_d  = wait_q;
    tout_d  = 1'b0;
`endif
    if (state_q == IDLE) begin
      do_arb = 1'b1;
    end else begin
      if (bus.bus_ready) begin
        beat_d = beat_q + BW'(1);
        do_arb = !(bus.lock[g] && bus.req[g] && (beat_q < BURST_LAST));
      end else begin
        do_arb = !bus.req[g];
      end
`ifdef WB_WATCHDOG_EN
      if (bus.bus_ready) begin
        wait_d = '0;
      end else if (wait_q == WAIT_LAST) begin
        do_arb = 1'b1;
        tout_d = 1'b1;
      end else begin
        wait_d = wait_q + WW'(1);
      end
`endif
      if (do_arb) ptr_d = next_g;
    end
    if (do_arb) begin
      beat_d = '0;
`ifdef WB_WATCHDOG_EN
      wait_d = '0;
`endif
      if (found) begin
        state_d = GRANT;
        gnt_d   = 6'b000001 << win;
        sel_d   = win;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = SEL_IDLE;
      end
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= SEL_IDLE;
      ptr_q   <= '0;
      beat_q  <= '0;
`ifdef WB_WATCHDOG_EN
      wait_q  <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
`ifdef WB_WATCHDOG_EN
      wait_q  <= wait_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.bus_valid = |gnt_q;
  assign bus.xfer      = (|gnt_q) & bus.bus_ready;
`ifdef WB_WATCHDOG_EN
  assign bus.timeout_err = tout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
